// File: rtl/bam_eval_pkg.sv
// rtl/bam_eval_pkg.sv - shared types and constants for the BAM multiplier error evaluator
//   state_e           : controller FSM states
//   LFSR_TAPS         : Galois feedback mask, x^16+x^14+x^13+x^11+1
//   LFSR_DEFAULT_SEED : reset value and replacement for an all-zero seed
//   DEF_*             : default parameter values for the top level
package bam_eval_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_SAMPLE_W = 20;
  localparam int DEF_SETTLE_W = 8;
  localparam int DEF_ACC_W    = 40;

  // One right shift of the Galois LFSR; taps are applied when the bit shifted out is 1.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    lfsr_next = cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
  endfunction

endpackage

// File: rtl/bam_lfsr16.sv
// rtl/bam_lfsr16.sv - 16-bit Galois LFSR operand source
//   clk, rst_n : clock, synchronous active-low reset (value returns to the default seed)
//   load, seed : load seed; a zero seed is replaced by the default seed (zero would lock up)
//   step       : advance one step (load has priority)
//   value      : current LFSR state
module bam_lfsr16
  import bam_eval_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] value
);

  logic [15:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
    end else if (step) begin
      value_d = lfsr_next(value_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_q <= LFSR_DEFAULT_SEED;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/bam_error_eval_ctrl.sv
// rtl/bam_error_eval_ctrl.sv - drives an approximate multiplier and accumulates error metrics
//   clk, rst_n                 : clock, synchronous active-low reset
//   start                      : run request, honoured only in IDLE
//   num_samples, settle_cycles : run length and per-sample settle wait, latched at start
//   seed                       : LFSR seed, latched at start
//   mul_a, mul_b, mul_p        : operands to / product from the multiplier under test
//   busy, done                 : run in progress / one-cycle end-of-run pulse
//   err_count, sum_ed_abs,
//   max_ed                     : error metrics of the last run
module bam_error_eval_ctrl
  import bam_eval_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int SETTLE_W = DEF_SETTLE_W,
  parameter int ACC_W    = DEF_ACC_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [SAMPLE_W-1:0]  num_samples,
  input  logic [SETTLE_W-1:0]  settle_cycles,
  input  logic [2*WIDTH-1:0]   seed,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic [2*WIDTH-1:0]   mul_p,
  output logic                 busy,
  output logic                 done,
  output logic [SAMPLE_W-1:0]  err_count,
  output logic [ACC_W-1:0]     sum_ed_abs,
  output logic [2*WIDTH-1:0]   max_ed
);

  localparam int PW = 2 * WIDTH;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    mul_a_q, mul_a_d;
  logic [WIDTH-1:0]    mul_b_q, mul_b_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [SAMPLE_W-1:0] err_q, err_d;
  logic [ACC_W-1:0]    sum_q, sum_d;
  logic [PW-1:0]       max_q, max_d;
  logic [SAMPLE_W-1:0] num_q, num_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] samp_q, samp_d;

  logic                lfsr_load, lfsr_step;
  logic [15:0]         lfsr_value;

  logic [PW-1:0]       exact;
  logic [PW-1:0]       ed;
  logic [ACC_W:0]      sum_ext;
  logic [SAMPLE_W-1:0] samp_inc;

  bam_lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .seed  (16'(seed)),
    .step  (lfsr_step),
    .value (lfsr_value)
  );

  // Reference product and unsigned error distance, both against the registered operands.
  always_comb begin
    exact = PW'(mul_a_q) * PW'(mul_b_q);
    ed    = (exact >= mul_p) ? (exact - mul_p) : (mul_p - exact);
  end

  // One extra bit catches the carry so the accumulator saturates instead of wrapping.
  assign sum_ext  = {1'b0, sum_q} + (ACC_W + 1)'(ed);
  assign samp_inc = samp_q + SAMPLE_W'(1);

  always_comb begin
    state_d   = state_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    err_d     = err_q;
    sum_d     = sum_q;
    max_d     = max_q;
    num_d     = num_q;
    settle_d  = settle_q;
    cnt_d     = cnt_q;
    samp_d    = samp_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_d     = num_samples;
          settle_d  = settle_cycles;
          err_d     = '0;
          sum_d     = '0;
          max_d     = '0;
          samp_d    = '0;
          lfsr_load = 1'b1;
          state_d   = (num_samples == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        mul_a_d = WIDTH'(lfsr_value[15:8]);
        mul_b_d = WIDTH'(lfsr_value[7:0]);
        cnt_d   = settle_q;
        state_d = (settle_q == '0) ? ST_SAMPLE : ST_SETTLE;
      end
      ST_SETTLE: begin
        // The counter holds the cycles left including this one.
        cnt_d = cnt_q - SETTLE_W'(1);
        if (cnt_q == SETTLE_W'(1)) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (ed != '0) begin
          err_d = err_q + SAMPLE_W'(1);
        end
        sum_d     = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
        if (ed > max_q) begin
          max_d = ed;
        end
        lfsr_step = 1'b1;
        samp_d    = samp_inc;
        state_d   = (samp_inc == num_q) ? ST_DONE : ST_LOAD;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status flags are registered from the next state so they line up with the state itself.
  assign busy_d = (state_d == ST_LOAD) || (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
  assign done_d = (state_d == ST_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= '0;
      sum_q    <= '0;
      max_q    <= '0;
      num_q    <= '0;
      settle_q <= '0;
      cnt_q    <= '0;
      samp_q   <= '0;
    end else begin
      state_q  <= state_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      sum_q    <= sum_d;
      max_q    <= max_d;
      num_q    <= num_d;
      settle_q <= settle_d;
      cnt_q    <= cnt_d;
      samp_q   <= samp_d;
    end
  end

  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err_count  = err_q;
  assign sum_ed_abs = sum_q;
  assign max_ed     = max_q;

endmodule

// File: tb/tb_bam_error_eval_ctrl.sv
// tb/tb_bam_error_eval_ctrl.sv - self-checking bench for bam_error_eval_ctrl
module tb_bam_error_eval_ctrl;

  localparam int M_EXACT = 0;  // approx == exact
  localparam int M_ZERO  = 1;  // approx == 0
  localparam int M_LSB0  = 2;  // exact with bit 0 cleared
  localparam int M_OR100 = 3;  // exact with bit 8 set (approx above exact)
  localparam int M_FLIP0 = 4;  // exact with bit 0 inverted

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [19:0] num_samples;
  logic [7:0]  settle_cycles;
  logic [15:0] seed;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [15:0] mul_p;
  logic        busy;
  logic        done;
  logic [19:0] err_count;
  logic [39:0] sum_ed_abs;
  logic [15:0] max_ed;

  int          mode;
  logic [15:0] ex;

  int n_cmp;
  int n_fail;

  bam_error_eval_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .num_samples   (num_samples),
    .settle_cycles (settle_cycles),
    .seed          (seed),
    .mul_a         (mul_a),
    .mul_b         (mul_b),
    .mul_p         (mul_p),
    .busy          (busy),
    .done          (done),
    .err_count     (err_count),
    .sum_ed_abs    (sum_ed_abs),
    .max_ed        (max_ed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier stand-in with selectable error behaviour.
  always_comb begin
    ex = 16'(mul_a) * 16'(mul_b);
    case (mode)
      M_EXACT: mul_p = ex;
      M_ZERO:  mul_p = 16'h0000;
      M_LSB0:  mul_p = ex & 16'hFFFE;
      M_OR100: mul_p = ex | 16'h0100;
      M_FLIP0: mul_p = ex ^ 16'h0001;
      default: mul_p = ex;
    endcase
  end

  typedef struct {
    logic [15:0] seed;
    int          num;
    int          settle;
    int          mode;
    longint      e_err;
    longint      e_sum;
    longint      e_max;
    int          e_lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one vector from the start edge to done; cycle 1 is the cycle after the start edge.
  task automatic run_vec(input int i);
    int cyc;
    int busy_cnt;
    int lat;
    seed          = vecs[i].seed;
    num_samples   = 20'(vecs[i].num);
    settle_cycles = 8'(vecs[i].settle);
    mode          = vecs[i].mode;
    start         = 1'b1;
    cyc           = 0;
    busy_cnt      = 0;
    lat           = -1;
    while (cyc < vecs[i].e_lat + 50) begin
      tick();
      start = 1'b0;
      cyc++;
      if (busy) busy_cnt++;
      if (done) begin
        lat = cyc;
        break;
      end
    end
    chk($sformatf("v%0d latency", i), lat, vecs[i].e_lat);
    chk($sformatf("v%0d busy_cycles", i), busy_cnt, vecs[i].num * (vecs[i].settle + 2));
    chk($sformatf("v%0d err_count", i), err_count, vecs[i].e_err);
    chk($sformatf("v%0d sum_ed_abs", i), sum_ed_abs, vecs[i].e_sum);
    chk($sformatf("v%0d max_ed", i), max_ed, vecs[i].e_max);
    tick();
    chk($sformatf("v%0d done_pulse", i), done, 0);
    chk($sformatf("v%0d hold_err", i), err_count, vecs[i].e_err);
  endtask

  initial begin
    int   lat;
    int   stray;
    logic d_seen [1:8];
    logic b_seen [1:8];

    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    mode   = M_EXACT;
    seed   = 16'h0;
    num_samples   = '0;
    settle_cycles = '0;

    //             seed      num   set mode     err sum    max    lat
    vecs[0] = '{16'h1234, 1000, 2, M_EXACT, 0,  0,     0,     4001};
    vecs[1] = '{16'h0302, 1,    3, M_ZERO,  1,  6,     6,     6};
    vecs[2] = '{16'h5555, 0,    5, M_ZERO,  0,  0,     0,     1};
    vecs[3] = '{16'h0101, 1,    0, M_LSB0,  1,  1,     1,     3};
    vecs[4] = '{16'h0302, 3,    1, M_ZERO,  3,  34695, 34560, 10};
    vecs[5] = '{16'hB4C0, 2,    0, M_ZERO,  2,  43200, 34560, 5};
    vecs[6] = '{16'h0302, 1,    2, M_OR100, 1,  256,   256,   5};
    vecs[7] = '{16'h0101, 50,   1, M_FLIP0, 50, 50,    1,     151};

    tick();
    tick();
    chk("rst mul_a", mul_a, 0);
    chk("rst mul_b", mul_b, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst err_count", err_count, 0);
    chk("rst sum_ed_abs", sum_ed_abs, 0);
    chk("rst max_ed", max_ed, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_vec(i);
      tick();
    end

    // Zero seed: first operands come from the default seed and hold across settle and sample.
    seed = 16'h0000; num_samples = 20'd1; settle_cycles = 8'd4; mode = M_EXACT;
    start = 1'b1;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      start = 1'b0;
      if (c >= 2 && c <= 6) begin
        chk($sformatf("seed0 mul_a c%0d", c), mul_a, 8'hAC);
        chk($sformatf("seed0 mul_b c%0d", c), mul_b, 8'hE1);
      end
      if (done && lat < 0) lat = c;
    end
    chk("seed0 latency", lat, 7);
    chk("seed0 err_count", err_count, 0);

    // start pulses while busy are ignored.
    seed = 16'h0302; num_samples = 20'd2; settle_cycles = 8'd1; mode = M_ZERO;
    start = 1'b1;
    lat = -1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      start = (c == 2 || c == 5) ? 1'b1 : 1'b0;
      if (done && lat < 0) lat = c;
      if (lat > 0) break;
    end
    start = 1'b0;
    chk("repulse latency", lat, 7);
    chk("repulse err_count", err_count, 2);
    chk("repulse sum_ed_abs", sum_ed_abs, 135);
    chk("repulse max_ed", max_ed, 129);
    stray = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (busy || done) stray++;
    end
    chk("repulse no_second_run", stray, 0);

    // start held high retriggers on the IDLE cycle after DONE.
    seed = 16'h0101; num_samples = 20'd1; settle_cycles = 8'd0; mode = M_EXACT;
    start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 5) start = 1'b0;
      d_seen[c] = done;
      b_seen[c] = busy;
    end
    chk("hold done c3", d_seen[3], 1);
    chk("hold busy c4", b_seen[4], 0);
    chk("hold done c4", d_seen[4], 0);
    chk("hold busy c5", b_seen[5], 1);
    chk("hold done c7", d_seen[7], 1);
    chk("hold done c8", d_seen[8], 0);
    tick();

    // Reset during the second sample's settle window aborts the run.
    seed = 16'h0302; num_samples = 20'd3; settle_cycles = 8'd3; mode = M_ZERO;
    start = 1'b1;
    stray = 0;
    for (int c = 1; c <= 7; c++) begin
      tick();
      start = 1'b0;
      if (done) stray++;
    end
    chk("abort busy_before", busy, 1);
    chk("abort partial_err", err_count, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort mul_a", mul_a, 0);
    chk("abort mul_b", mul_b, 0);
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort err_count", err_count, 0);
    chk("abort sum_ed_abs", sum_ed_abs, 0);
    chk("abort max_ed", max_ed, 0);
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done || busy) stray++;
    end
    chk("abort stays_idle", stray, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bam_error_eval_ctrl.md
Name: bam_error_eval_ctrl

Overview:
- Hardware sequencer that drives an external approximate 8x8 multiplier (BAM/CSA-style, combinational, ports A/B/P) with pseudo-random operands.
- Waits a programmable settle time, then samples the product and compares it with an internally computed exact product.
- Accumulates error metrics: error count, sum of absolute error distance, maximum error distance.
- Sits beside the multiplier under evaluation; replaces the simulation-only error bench for on-chip/FPGA characterisation.

Parameters:
- WIDTH, 8, operand width; product width is 2*WIDTH.
- SAMPLE_W, 20, width of sample count and error count.
- SETTLE_W, 8, width of settle-cycle count.
- ACC_W, 40, width of the absolute-error-distance accumulator.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  run request, sampled only in IDLE.
- num_samples  in  SAMPLE_W  samples per run, latched at start.
- settle_cycles  in  SETTLE_W  wait cycles between operand update and product capture, latched at start.
- seed  in  2*WIDTH  LFSR seed, latched at start.
- mul_a  out  WIDTH  operand A to multiplier.
- mul_b  out  WIDTH  operand B to multiplier.
- mul_p  in  2*WIDTH  approximate product from multiplier.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.
- err_count  out  SAMPLE_W  samples with exact != approx.
- sum_ed_abs  out  ACC_W  sum of |exact - approx|.
- max_ed  out  2*WIDTH  largest |exact - approx| seen.

Behaviour:
- Reset (rst_n=0 at a rising edge): state IDLE. All outputs 0: mul_a, mul_b, busy, done, err_count, sum_ed_abs, max_ed. LFSR = 16'hACE1. Reset mid-run aborts the run with no done pulse.
- The FSM states are IDLE, LOAD, SETTLE, SAMPLE, DONE. All outputs are registered.
- IDLE, start=1:
  - Latch num_samples, settle_cycles and seed. If seed is 0, substitute 16'hACE1.
  - Clear err_count, sum_ed_abs, max_ed and the internal sample counter.
  - Go to LOAD, or go straight to DONE when num_samples==0 (results stay 0).
- LOAD (1 cycle):
  - mul_a <= lfsr[15:8], mul_b <= lfsr[7:0].
  - Settle counter <= settle_cycles.
  - Go to SETTLE, or to SAMPLE if settle_cycles==0.
- SETTLE: decrement the settle counter each cycle. After settle_cycles cycles in SETTLE, go to SAMPLE.
- SAMPLE (1 cycle):
  - exact = mul_a*mul_b (full 2*WIDTH bits); ed = |exact - mul_p|, unsigned magnitude.
  - If ed != 0, err_count += 1.
  - sum_ed_abs += ed, zero-extended; saturate at all-ones (cannot saturate at default widths).
  - If ed > max_ed, max_ed <= ed.
  - Advance the LFSR one step; sample counter += 1.
  - If the counter now equals num_samples, go to DONE; else go to LOAD.
- DONE (1 cycle): done=1, then go to IDLE.
- busy=1 exactly in LOAD, SETTLE, SAMPLE.
- Results hold after done until the next accepted start.
- mul_a/mul_b are stable from LOAD through SAMPLE and hold their last value in IDLE.
- start outside IDLE is ignored, not queued. start held high re-triggers a run on the IDLE cycle after DONE.
- Per-sample cost is settle_cycles+2 cycles. Run latency from the start edge to done is 1 + num_samples*(settle_cycles+2) cycles.
- The LFSR is 16-bit Galois, shift right; when the LSB is 1, XOR with 16'hB400 (x^16+x^14+x^13+x^11+1). Period is 65535.

Decomposition:
- Package bam_eval_pkg holds:
  - state enum (IDLE, LOAD, SETTLE, SAMPLE, DONE);
  - LFSR_TAPS = 16'hB400;
  - LFSR_DEFAULT_SEED = 16'hACE1;
  - default parameter constants.
- One sub-module, bam_lfsr16: ports clk, rst_n, load, seed, step, value. Handles the zero-seed substitution internally.
- Exact multiply, abs-difference and accumulators stay in the top level.

Test Plan:
- Exact-multiplier model on mul_p, seed=16'h1234, num_samples=1000, settle_cycles=2 -> err_count=0, sum_ed_abs=0, max_ed=0; done exactly 4001 cycles after the start edge.
- Model drives mul_p=0, seed=16'h0302 (A=3, B=2), num_samples=1, settle_cycles=3 -> done at start+6; busy high start+1..start+5; err_count=1, sum_ed_abs=6, max_ed=6.
- num_samples=0, start pulse -> done at start+1; busy never high; all results 0.
- Model returns exact with bit 0 forced to 0, seed=16'h0101 (A=1, B=1), num_samples=1, settle_cycles=0 -> exact=1, approx=0; err_count=1, sum_ed_abs=1, max_ed=1; done at start+3.
- start re-pulsed while busy -> ignored; results match a single uninterrupted run. rst_n=0 mid-SETTLE -> next cycle all outputs 0, state IDLE, no done pulse.
- seed=0 -> first operands are A=8'hAC, B=8'hE1; mul_a/mul_b observed stable for the whole settle window.
